// File: rtl/mips_bus_pkg.sv
// Shared types and lane constants for the MIPS Avalon load/store unit.
package mips_bus_pkg;

  // Access size encoding carried on ch_size.
  typedef enum logic [2:0] {
    SZ_BYTE = 3'd0,
    SZ_HALF = 3'd1,
    SZ_WORD = 3'd2,
    SZ_LWL  = 3'd3,
    SZ_LWR  = 3'd4
  } size_t;

  // Bus master sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  localparam logic [3:0]  BE_NONE  = 4'h0;
  localparam logic [3:0]  BE_BYTE  = 4'h1;
  localparam logic [3:0]  BE_HALF  = 4'h3;
  localparam logic [3:0]  BE_WORD  = 4'hF;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  // Bit shift corresponding to a byte lane index.
  function automatic logic [4:0] lane_shift(input logic [1:0] k);
    return {k, 3'b000};
  endfunction

endpackage

// File: rtl/mips_lane_align.sv
// Combinational byte-lane steering: byteenable, store positioning, load
// extraction/merge and legality of a (size, alignment, direction) tuple.
module mips_lane_align
  import mips_bus_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  k_i,
  input  logic        we_i,
  input  logic        sext_i,
  input  logic [31:0] wdata_i,   // store data, or old rt for LWL/LWR
  input  logic [31:0] rdata_i,   // raw bus read data
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] result_o,
  output logic        illegal_o
);

  logic [4:0]  sh_lo_s;   // 8*k
  logic [4:0]  sh_hi_s;   // 8*(3-k)
  logic [31:0] lane_s;    // read data with lane k moved to bit 0

  assign sh_lo_s = lane_shift(k_i);
  assign sh_hi_s = lane_shift(2'd3 - k_i);
  assign lane_s  = rdata_i >> sh_lo_s;

  // Decode size into lanes, data steering and the illegal flag.
  always_comb begin
    be_o      = BE_NONE;
    wdata_o   = wdata_i;
    result_o  = rdata_i;
    illegal_o = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        be_o     = BE_BYTE << k_i;
        wdata_o  = wdata_i << sh_lo_s;
        result_o = sext_i ? {{24{lane_s[7]}}, lane_s[7:0]} : {24'h000000, lane_s[7:0]};
      end
      SZ_HALF: begin
        illegal_o = k_i[0];
        be_o      = BE_HALF << k_i;
        wdata_o   = wdata_i << sh_lo_s;
        result_o  = sext_i ? {{16{lane_s[15]}}, lane_s[15:0]} : {16'h0000, lane_s[15:0]};
      end
      SZ_WORD: begin
        illegal_o = (k_i != 2'd0);
        be_o      = BE_WORD;
        wdata_o   = wdata_i;
        result_o  = rdata_i;
      end
      SZ_LWL: begin
        // Low k+1 memory bytes land in the top of rt; rest of rt kept.
        illegal_o = we_i;
        be_o      = BE_WORD >> (2'd3 - k_i);
        result_o  = (rdata_i << sh_hi_s) | (wdata_i & ~(ALL_ONES << sh_hi_s));
      end
      SZ_LWR: begin
        // Memory bytes k..3 land in the bottom of rt; rest of rt kept.
        illegal_o = we_i;
        be_o      = BE_WORD << k_i;
        result_o  = (rdata_i >> sh_lo_s) | (wdata_i & ~(ALL_ONES >> sh_lo_s));
      end
      default: begin
        illegal_o = 1'b1;
        be_o      = BE_NONE;
      end
    endcase
  end

endmodule

// File: rtl/mips_avalon_lsu.sv
// Multi-channel Avalon-MM master: round-robin arbitration, one transfer in
// flight, lane alignment via mips_lane_align, optional waitrequest watchdog.
module mips_avalon_lsu
  import mips_bus_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_CH-1:0]      ch_req,
  input  logic [N_CH-1:0]      ch_we,
  input  logic [N_CH*ADDR_W-1:0] ch_addr,
  input  logic [N_CH*3-1:0]    ch_size,
  input  logic [N_CH-1:0]      ch_sext,
  input  logic [N_CH*32-1:0]   ch_wdata,
  output logic [31:0]          ch_rdata,
  output logic [N_CH-1:0]      ch_done,
  output logic [N_CH-1:0]      ch_err,
  output logic [ADDR_W-1:0]    address,
  output logic                 read,
  output logic                 write,
  input  logic                 waitrequest,
  output logic [31:0]          writedata,
  output logic [3:0]           byteenable,
  input  logic [31:0]          readdata
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CH_W-1:0]  RR_INIT  = CH_W'(N_CH - 1);
  localparam logic [N_CH-1:0]  CH_ONE   = N_CH'(1);

  lsu_state_t        state_q, state_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [CH_W-1:0]   sel_q, sel_d;
  logic              we_q, we_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        k_q, k_d;
  logic              sext_q, sext_d;
  logic [31:0]       old_q, old_d;
  logic              errf_q, errf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [N_CH-1:0]   done_q, done_d;
  logic [N_CH-1:0]   err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              grant_valid_s;
  logic [CH_W-1:0]   grant_s;
  logic [ADDR_W-1:0] cand_addr_s;
  logic [2:0]        cand_size_s;
  logic              cand_we_s;
  logic              cand_sext_s;
  logic [31:0]       cand_wdata_s;

  logic [2:0]        al_size_s;
  logic [1:0]        al_k_s;
  logic              al_we_s;
  logic              al_sext_s;
  logic [31:0]       al_old_s;
  logic [3:0]        al_be_s;
  logic [31:0]       al_wdata_s;
  logic [31:0]       al_result_s;
  logic              al_illegal_s;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_s       = rr_q;
    for (int i = 1; i <= N_CH; i++) begin
      if (!grant_valid_s && ch_req[(int'(rr_q) + i) % N_CH]) begin
        grant_valid_s = 1'b1;
        grant_s       = CH_W'((int'(rr_q) + i) % N_CH);
      end
    end
  end

  assign cand_addr_s  = ch_addr[int'(grant_s)*ADDR_W +: ADDR_W];
  assign cand_size_s  = ch_size[int'(grant_s)*3 +: 3];
  assign cand_we_s    = ch_we[grant_s];
  assign cand_sext_s  = ch_sext[grant_s];
  assign cand_wdata_s = ch_wdata[int'(grant_s)*32 +: 32];

  // The aligner sees the candidate while idle, the latched request otherwise.
  assign al_size_s = (state_q == IDLE) ? cand_size_s      : size_q;
  assign al_k_s    = (state_q == IDLE) ? cand_addr_s[1:0] : k_q;
  assign al_we_s   = (state_q == IDLE) ? cand_we_s        : we_q;
  assign al_sext_s = (state_q == IDLE) ? cand_sext_s      : sext_q;
  assign al_old_s  = (state_q == IDLE) ? cand_wdata_s     : old_q;

  mips_lane_align u_align (
    .size_i    (al_size_s),
    .k_i       (al_k_s),
    .we_i      (al_we_s),
    .sext_i    (al_sext_s),
    .wdata_i   (al_old_s),
    .rdata_i   (readdata),
    .be_o      (al_be_s),
    .wdata_o   (al_wdata_s),
    .result_o  (al_result_s),
    .illegal_o (al_illegal_s)
  );

  // Next-state and registered-output computation for the bus FSM.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    sel_d     = sel_q;
    we_d      = we_q;
    size_d    = size_q;
    k_d       = k_q;
    sext_d    = sext_q;
    old_d     = old_q;
    errf_d    = errf_q;
    cnt_d     = cnt_q;
    read_d    = read_q;
    write_d   = write_q;
    address_d = address_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    done_d    = '0;
    err_d     = '0;
    case (state_q)
      IDLE: begin
        if (grant_valid_s) begin
          rr_d   = grant_s;
          sel_d  = grant_s;
          we_d   = cand_we_s;
          size_d = cand_size_s;
          k_d    = cand_addr_s[1:0];
          sext_d = cand_sext_s;
          old_d  = cand_wdata_s;
          cnt_d  = '0;
          if (al_illegal_s) begin
            errf_d  = 1'b1;
            state_d = RESP;
          end else begin
            errf_d    = 1'b0;
            state_d   = BUS;
            address_d = {cand_addr_s[ADDR_W-1:2], 2'b00};
            be_d      = al_be_s;
            wdata_d   = al_wdata_s;
            read_d    = ~cand_we_s;
            write_d   = cand_we_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUS: begin
        if (!waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = RESP;
          if (read_q) begin
            rdata_d = al_result_s;
          end else begin
            rdata_d = rdata_q;
          end
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          errf_d  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        if (errf_q) begin
          err_d = CH_ONE << sel_q;
        end else begin
          done_d = CH_ONE << sel_q;
        end
      end
      default: begin
        state_d = IDLE;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops read/write immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_q      <= RR_INIT;
      sel_q     <= '0;
      we_q      <= 1'b0;
      size_q    <= 3'd0;
      k_q       <= 2'd0;
      sext_q    <= 1'b0;
      old_q     <= 32'h0;
      errf_q    <= 1'b0;
      cnt_q     <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      address_q <= '0;
      be_q      <= 4'h0;
      wdata_q   <= 32'h0;
      rdata_q   <= 32'h0;
      done_q    <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      size_q    <= size_d;
      k_q       <= k_d;
      sext_q    <= sext_d;
      old_q     <= old_d;
      errf_q    <= errf_d;
      cnt_q     <= cnt_d;
      read_q    <= read_d;
      write_q   <= write_d;
      address_q <= address_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign ch_rdata   = rdata_q;
  assign ch_done    = done_q;
  assign ch_err     = err_q;
  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = wdata_q;
  assign byteenable = be_q;

endmodule

// File: tb/tb_mips_avalon_lsu.sv
// Directed bench for mips_avalon_lsu: one instance without watchdog, one with TIMEOUT=4.
module tb_mips_avalon_lsu;

  logic        clk = 1'b0;
  logic        rst;

  logic [1:0]  ch_req, ch_we, ch_sext;
  logic [63:0] ch_addr, ch_wdata;
  logic [5:0]  ch_size;
  logic        waitreq;
  logic [31:0] rdin;
  logic [31:0] ch_rdata, writedata;
  logic [1:0]  ch_done, ch_err;
  logic [31:0] address;
  logic        rd, wr;
  logic [3:0]  be;

  logic [1:0]  t_req, t_we, t_sext;
  logic [63:0] t_addr, t_wdata;
  logic [5:0]  t_size;
  logic        t_wait;
  logic [31:0] t_rdata, t_writedata, t_address;
  logic [1:0]  t_done, t_err;
  logic        t_rd, t_wr;
  logic [3:0]  t_be;

  int n_pass  = 0;
  int n_total = 0;

  mips_avalon_lsu #(.N_CH(2), .ADDR_W(32), .TIMEOUT(0)) u_dut (
    .clk(clk), .reset(rst),
    .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr), .ch_size(ch_size),
    .ch_sext(ch_sext), .ch_wdata(ch_wdata), .ch_rdata(ch_rdata),
    .ch_done(ch_done), .ch_err(ch_err), .address(address), .read(rd),
    .write(wr), .waitrequest(waitreq), .writedata(writedata),
    .byteenable(be), .readdata(rdin)
  );

  mips_avalon_lsu #(.N_CH(2), .ADDR_W(32), .TIMEOUT(4)) u_dut_to (
    .clk(clk), .reset(rst),
    .ch_req(t_req), .ch_we(t_we), .ch_addr(t_addr), .ch_size(t_size),
    .ch_sext(t_sext), .ch_wdata(t_wdata), .ch_rdata(t_rdata),
    .ch_done(t_done), .ch_err(t_err), .address(t_address), .read(t_rd),
    .write(t_wr), .waitrequest(t_wait), .writedata(t_writedata),
    .byteenable(t_be), .readdata(32'hDEAD_BEEF)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic set_ch(input int c, input logic we, input logic [31:0] a,
                        input logic [2:0] sz, input logic sx, input logic [31:0] wd);
    ch_we[c]          = we;
    ch_addr[c*32+:32] = a;
    ch_size[c*3+:3]   = sz;
    ch_sext[c]        = sx;
    ch_wdata[c*32+:32] = wd;
    ch_req[c]         = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    ch_req = '0; ch_we = '0; ch_sext = '0; ch_addr = '0; ch_wdata = '0; ch_size = '0;
    waitreq = 1'b0; rdin = 32'h0;
    t_req = '0; t_we = '0; t_sext = '0; t_addr = '0; t_wdata = '0; t_size = '0; t_wait = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_read", {31'h0, rd}, 32'h0);
    chk("rst_write", {31'h0, wr}, 32'h0);
    chk("rst_be", {28'h0, be}, 32'h0);
    chk("rst_addr", address, 32'h0);
    chk("rst_wdata", writedata, 32'h0);
    chk("rst_done_err", {28'h0, ch_done, ch_err}, 32'h0);
    chk("rst_rdata", ch_rdata, 32'h0);
    rst = 1'b0;

    // LW ch1 0x1004, no stall
    rdin = 32'h1234_5678;
    set_ch(1, 1'b0, 32'h0000_1004, 3'd2, 1'b0, 32'h0);
    tick();
    chk("lw_read", {31'h0, rd}, 32'h1);
    chk("lw_addr", address, 32'h0000_1004);
    chk("lw_be", {28'h0, be}, 32'hF);
    tick();
    chk("lw_read_drop", {31'h0, rd}, 32'h0);
    chk("lw_done_early", {30'h0, ch_done}, 32'h0);
    tick();
    chk("lw_done", {30'h0, ch_done}, 32'h2);
    chk("lw_rdata", ch_rdata, 32'h1234_5678);
    ch_req[1] = 1'b0;
    tick();
    chk("lw_done_pulse", {30'h0, ch_done}, 32'h0);

    // LB signed ch0 0x1003
    rdin = 32'h80FF_FFFF;
    set_ch(0, 1'b0, 32'h0000_1003, 3'd0, 1'b1, 32'h0);
    tick();
    chk("lb_be", {28'h0, be}, 32'h8);
    chk("lb_addr", address, 32'h0000_1000);
    tick(); tick();
    chk("lb_done", {30'h0, ch_done}, 32'h1);
    chk("lb_rdata", ch_rdata, 32'hFFFF_FF80);
    ch_req[0] = 1'b0;
    tick();

    // LBU same address
    set_ch(0, 1'b0, 32'h0000_1003, 3'd0, 1'b0, 32'h0);
    tick(); tick(); tick();
    chk("lbu_rdata", ch_rdata, 32'h0000_0080);
    ch_req[0] = 1'b0;
    tick();

    // SH ch0 0x2002 with 5 stall cycles
    waitreq = 1'b1;
    set_ch(0, 1'b1, 32'h0000_2002, 3'd1, 1'b0, 32'h0000_BEEF);
    tick();
    chk("sh_write", {31'h0, wr}, 32'h1);
    chk("sh_be", {28'h0, be}, 32'hC);
    chk("sh_wdata", writedata, 32'hBEEF_0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sh_write_held", {31'h0, wr, 1'b0} | {31'h0, rd}, 32'h2);
    end
    chk("sh_wdata_held", writedata, 32'hBEEF_0000);
    waitreq = 1'b0;
    tick();
    chk("sh_write_drop", {31'h0, wr}, 32'h0);
    tick();
    chk("sh_done", {30'h0, ch_done}, 32'h1);
    ch_req[0] = 1'b0;
    tick();

    // LWL ch1 0x3001
    rdin = 32'hAABB_CCDD;
    set_ch(1, 1'b0, 32'h0000_3001, 3'd3, 1'b0, 32'h1122_3344);
    tick();
    chk("lwl_be", {28'h0, be}, 32'h3);
    tick(); tick();
    chk("lwl_rdata", ch_rdata, 32'hCCDD_3344);
    ch_req[1] = 1'b0;
    tick();

    // LWR ch1 0x3001
    set_ch(1, 1'b0, 32'h0000_3001, 3'd4, 1'b0, 32'h1122_3344);
    tick();
    chk("lwr_be", {28'h0, be}, 32'hE);
    tick(); tick();
    chk("lwr_rdata", ch_rdata, 32'h11AA_BBCC);
    ch_req[1] = 1'b0;
    tick();

    // Round robin with both channels requesting continuously
    set_ch(0, 1'b0, 32'h0000_5000, 3'd2, 1'b0, 32'h0);
    set_ch(1, 1'b0, 32'h0000_6000, 3'd2, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_addr", address, (i % 2 == 0) ? 32'h0000_5000 : 32'h0000_6000);
      tick(); tick();
      chk("rr_done", {30'h0, ch_done}, (i % 2 == 0) ? 32'h1 : 32'h2);
    end
    ch_req = 2'b00;
    tick();

    // Misaligned LW ch0 0x4002
    set_ch(0, 1'b0, 32'h0000_4002, 3'd2, 1'b0, 32'h0);
    tick();
    chk("mis_no_read", {31'h0, rd}, 32'h0);
    tick();
    chk("mis_err", {30'h0, ch_err}, 32'h1);
    chk("mis_no_done", {30'h0, ch_done}, 32'h0);
    chk("mis_no_read2", {31'h0, rd}, 32'h0);
    ch_req[0] = 1'b0;
    tick();
    chk("mis_err_pulse", {30'h0, ch_err}, 32'h0);

    // Store with LWL size is illegal
    set_ch(1, 1'b1, 32'h0000_3000, 3'd3, 1'b0, 32'h0);
    tick();
    chk("swl_no_write", {31'h0, wr}, 32'h0);
    tick();
    chk("swl_err", {30'h0, ch_err}, 32'h2);
    ch_req[1] = 1'b0;
    tick();

    // Watchdog instance: waitrequest stuck high
    t_wait = 1'b1;
    t_addr[31:0] = 32'h0000_7000; t_size[2:0] = 3'd2; t_we[0] = 1'b0; t_req[0] = 1'b1;
    tick();
    chk("to_read", {31'h0, t_rd}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_read_held", {31'h0, t_rd}, 32'h1);
    end
    tick();
    chk("to_read_drop", {31'h0, t_rd}, 32'h0);
    tick();
    chk("to_err", {30'h0, t_err}, 32'h1);
    chk("to_no_done", {30'h0, t_done}, 32'h0);
    t_req[0] = 1'b0;
    tick();

    // Reset mid-BUS on the main instance
    waitreq = 1'b1;
    set_ch(0, 1'b0, 32'h0000_9000, 3'd2, 1'b0, 32'h0);
    tick();
    chk("mid_read", {31'h0, rd}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_read", {31'h0, rd}, 32'h0);
    ch_req[0] = 1'b0;
    tick();
    rst = 1'b0;
    waitreq = 1'b0;
    rdin = 32'hCAFE_F00D;
    set_ch(1, 1'b0, 32'h0000_8000, 3'd2, 1'b0, 32'h0);
    tick();
    chk("post_rst_read", {31'h0, rd}, 32'h1);
    chk("post_rst_addr", address, 32'h0000_8000);
    tick(); tick();
    chk("post_rst_done", {30'h0, ch_done}, 32'h2);
    chk("post_rst_rdata", ch_rdata, 32'hCAFE_F00D);
    ch_req[1] = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
